// File: rtl/delay_line_mc.sv
`default_nettype none
// ============================================================================
// delay_line_mc: multi-channel edge timestamper and burst replayer; option
// DELAY_LINE_MC_MODULATION_EN selects a square-wave burst. Revision 1.0
// ============================================================================
module delay_line_mc #(
  parameter int CHANNELS         = 4,
  parameter int CTR_WIDTH        = 18,
  parameter int FIFO_DEPTH       = 1024,
  parameter int DEFAULT_DELAY    = 165000,
  parameter int HOLDOFF_CYCLES   = 248,
  parameter int HALF_PERIOD_CLKS = 5,
  parameter int BURST_PULSES     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  in,
  input  logic [CTR_WIDTH-1:0] delay_cycles,
  input  logic                 delay_load,
  output logic                 delay_ack,
  input  logic                 overflow_clr,
  output logic [CHANNELS-1:0]  out,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic                 busy
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int HO_W    = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int HP_W    = (HALF_PERIOD_CLKS > 1) ? $clog2(HALF_PERIOD_CLKS) : 1;
  localparam int HB_W    = $clog2(2 * BURST_PULSES);
  localparam int ENTRY_W = CHANNELS + CTR_WIDTH;
  localparam logic [CTR_WIDTH-1:0] PIPE      = CTR_WIDTH'(3);
  localparam logic [CTR_WIDTH-1:0] MIN_DELAY = CTR_WIDTH'(6);

  typedef enum logic [0:0] {B_IDLE = 1'b0, B_ACTIVE = 1'b1} burst_state_e;

  logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
  logic [CTR_WIDTH-1:0] dly_q, dly_d;
  logic                 ack_q, ack_d;
  logic                 ovf_q, ovf_d;
  logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];

  logic [CHANNELS-1:0]  accept, trig, active;
  logic [ENTRY_W-1:0]   head;
  logic [CTR_WIDTH-1:0] target;
  logic                 full, empty, push, drop, pop;

  // Target is pre-compensated for the 3 clocks between in sampling and pop.
  assign target = ctr_q + dly_q - PIPE;
  assign full   = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign push   = (|accept) & ~full;
  assign drop   = (|accept) & full;
  assign head   = mem_q[rd_q];
  assign pop    = ~empty && (head[CTR_WIDTH-1:0] == ctr_q);
  assign trig   = pop ? head[ENTRY_W-1:CTR_WIDTH] : '0;

  assign busy      = ~empty | (|active);
  assign fifo_full = full;
  assign overflow  = ovf_q;
  assign delay_ack = ack_q;

  always_comb begin
    ctr_d = ctr_q + 1'b1;
    dly_d = dly_q;
    ack_d = 1'b0;
    if (delay_load && !busy) begin
      dly_d = (delay_cycles < MIN_DELAY) ? MIN_DELAY : delay_cycles;
      ack_d = 1'b1;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q <= '0;
      dly_q <= CTR_WIDTH'(DEFAULT_DELAY);
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ctr_q <= ctr_d;
      dly_q <= dly_d;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {accept, target};
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [2:0]      sync_q, sync_d;
    logic            edge_q, edge_d;
    logic [HO_W-1:0] hold_q, hold_d;
    burst_state_e    st_q, st_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [HB_W-1:0] half_q, half_d;

    assign accept[c] = edge_q & (hold_q == '0);
    assign active[c] = (st_q == B_ACTIVE);

    always_comb begin
      sync_d = {sync_q[1:0], in[c]};
      edge_d = sync_q[1] & ~sync_q[2];
      hold_d = hold_q;
      if (accept[c]) begin
        hold_d = HO_W'(HOLDOFF_CYCLES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end
      st_d   = st_q;
      hp_d   = hp_q;
      half_d = half_q;
      if (trig[c]) begin
        st_d   = B_ACTIVE;
        hp_d   = '0;
        half_d = HB_W'(2 * BURST_PULSES - 1);
      end else if (st_q == B_ACTIVE) begin
        if (hp_q == HP_W'(HALF_PERIOD_CLKS - 1)) begin
          hp_d = '0;
          if (half_q == '0) begin
            st_d = B_IDLE;
          end else begin
            half_d = half_q - 1'b1;
          end
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        edge_q <= 1'b0;
        hold_q <= '0;
        st_q   <= B_IDLE;
        hp_q   <= '0;
        half_q <= '0;
      end else begin
        sync_q <= sync_d;
        edge_q <= edge_d;
        hold_q <= hold_d;
        st_q   <= st_d;
        hp_q   <= hp_d;
        half_q <= half_d;
      end
    end

`ifdef DELAY_LINE_MC_MODULATION_EN
    logic lvl_q, lvl_d;

    // Level toggles at each half-period boundary; every burst starts high.
    always_comb begin
      lvl_d = lvl_q;
      if (trig[c]) begin
        lvl_d = 1'b1;
      end else if (st_q == B_ACTIVE && hp_q == HP_W'(HALF_PERIOD_CLKS - 1)) begin
        lvl_d = ~lvl_q;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lvl_q <= 1'b0;
      end else begin
        lvl_q <= lvl_d;
      end
    end

    assign out[c] = active[c] & lvl_q;
`else
    assign out[c] = active[c];
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_line_mc.sv
`default_nettype none
// ============================================================================
// tb_delay_line_mc: directed vector bench for delay_line_mc. Revision 1.0
// ============================================================================
module tb_delay_line_mc;
  localparam int CH   = 2;
  localparam int CW   = 8;
  localparam int FD   = 4;
  localparam int HO   = 10;
  localparam int HP   = 2;
  localparam int BP   = 3;
  localparam int DD   = 20;
  localparam int BLEN = 2 * HP * BP;
`ifdef DELAY_LINE_MC_MODULATION_EN
  localparam bit MOD = 1'b1;
`else
  localparam bit MOD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] in_drv = '0;
  logic [CW-1:0] delay_cycles = '0;
  logic          delay_load = 1'b0;
  logic          delay_ack;
  logic          overflow_clr = 1'b0;
  logic [CH-1:0] out;
  logic          fifo_full, overflow, busy;
  logic [CW-1:0] mctr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [CH-1:0] m;      // channels fired
    int            load_d; // delay to load first, 0 = keep
    int            d;      // effective delay
    int            s2;     // offset of a second pulse, -1 = none
    bit            acc2;   // second pulse survives holdoff
  } vec_t;

  vec_t tbl [10];

  delay_line_mc #(
    .CHANNELS(CH), .CTR_WIDTH(CW), .FIFO_DEPTH(FD), .DEFAULT_DELAY(DD),
    .HOLDOFF_CYCLES(HO), .HALF_PERIOD_CLKS(HP), .BURST_PULSES(BP)
  ) dut (
    .clk(clk), .rst(rst), .in(in_drv), .delay_cycles(delay_cycles),
    .delay_load(delay_load), .delay_ack(delay_ack), .overflow_clr(overflow_clr),
    .out(out), .fifo_full(fifo_full), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected timestamp counter, used only to place the wrap-around event.
  always @(posedge clk or posedge rst) begin
    if (rst) mctr <= '0;
    else     mctr <= mctr + 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic lvl(input int j);
    return MOD ? (((j / HP) % 2) == 0) : 1'b1;
  endfunction

  // i counts posedges after the first one that samples the pulse high.
  function automatic logic [CH-1:0] exp_out(input vec_t v, input int i);
    if (v.acc2 && i >= v.d + v.s2 && i < v.d + v.s2 + BLEN)
      return lvl(i - v.d - v.s2) ? v.m : '0;
    if (i >= v.d && i < v.d + BLEN)
      return lvl(i - v.d) ? v.m : '0;
    return '0;
  endfunction

  task automatic load_delay(input int d, input logic exp_ack, input string nm);
    delay_cycles = CW'(d);
    delay_load   = 1'b1;
    step();
    delay_load   = 1'b0;
    chk({nm, "_ack"}, delay_ack, exp_ack);
    step();
    chk({nm, "_ack_pulse"}, delay_ack, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    if (v.load_d != 0) load_delay(v.load_d, 1'b1, $sformatf("vec%0d_load", idx));
    if (v.d >= 128) begin
      for (int g = 0; g < 300 && mctr != 8'd249; g++) step();
    end
    in_drv = v.m;
    n = v.d + ((v.s2 > 0) ? v.s2 : 0) + BLEN + 3;
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("vec%0d_out@%0d", idx, i), out, exp_out(v, i));
      if (i == 1) in_drv = '0;
      if (v.s2 > 0 && i == v.s2 - 1) in_drv = v.m;
      if (v.s2 > 0 && i == v.s2 + 1) in_drv = '0;
    end
    chk($sformatf("vec%0d_busy", idx), busy, 1'b0);
    chk($sformatf("vec%0d_overflow", idx), overflow, 1'b0);
    chk($sformatf("vec%0d_full", idx), fifo_full, 1'b0);
    repeat (HO + 4) step();
  endtask

  initial begin
    int hi;
    tbl[0] = '{2'b01, 0,   DD,  -1, 1'b0};
    tbl[1] = '{2'b10, 0,   DD,  -1, 1'b0};
    tbl[2] = '{2'b11, 0,   DD,  -1, 1'b0};
    tbl[3] = '{2'b01, 0,   DD,   5, 1'b0};
    tbl[4] = '{2'b01, 0,   DD,  10, 1'b0};
    tbl[5] = '{2'b01, 0,   DD,  11, 1'b1};
    tbl[6] = '{2'b01, 3,   6,   -1, 1'b0};
    tbl[7] = '{2'b10, 9,   9,   -1, 1'b0};
    tbl[8] = '{2'b01, 200, 200, -1, 1'b0};
    tbl[9] = '{2'b01, 20,  20,  -1, 1'b0};

    step();
    step();
    chk("rst_out", out, 2'b00);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", delay_ack, 1'b0);
    rst = 1'b0;
    repeat (HO) step();

    for (int t = 0; t < 10; t++) run_vec(tbl[t], t);

    // Overflow: five edges 12 clocks apart with D = 100 and a 4-deep FIFO.
    load_delay(100, 1'b1, "d100");
    in_drv = 2'b01;
    hi = 0;
    for (int i = 0; i < 175; i++) begin
      step();
      if (out[0]) hi++;
      chk($sformatf("ovf_out1@%0d", i), out[1], 1'b0);
      if (i == 38)  chk("ovf_full_before", fifo_full, 1'b0);
      if (i == 39)  chk("ovf_full_after", fifo_full, 1'b1);
      if (i == 99)  chk("ovf_full_prepop", fifo_full, 1'b1);
      if (i == 100) chk("ovf_full_postpop", fifo_full, 1'b0);
      if (i == 100) chk("ovf_first_burst", out[0], 1'b1);
      if (i == 50)  chk("ovf_flag_before", overflow, 1'b0);
      if (i == 51)  chk("ovf_flag_after", overflow, 1'b1);
      if (i == 60) begin
        delay_cycles = 8'd3;
        delay_load   = 1'b1;
      end
      if (i == 61) begin
        chk("busy_load_ignored", delay_ack, 1'b0);
        delay_load = 1'b0;
      end
      in_drv[0] = (((i + 1) % 12) < 2) && ((i + 1) < 60);
    end
    chk("ovf_high_cycles", hi, 4 * (MOD ? BLEN / 2 : BLEN));
    chk("ovf_idle_busy", busy, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 1'b0);
    step();
    chk("ovf_clr_hold", overflow, 1'b0);

    // Simultaneous edges share one entry; D must still be 100.
    in_drv = 2'b11;
    for (int i = 0; i < 160; i++) begin
      step();
      if (i == 38)  chk("sim_full_before", fifo_full, 1'b0);
      if (i == 39)  chk("sim_full_after", fifo_full, 1'b1);
      if (i == 45)  chk("sim_no_overflow", overflow, 1'b0);
      if (i == 99)  chk("sim_out_pre", out, 2'b00);
      if (i == 100) chk("sim_out_both", out, 2'b11);
      if (i == 112) chk("sim_out_ch1_2", out, 2'b10);
      if (i == 124) chk("sim_out_ch1_3", out, 2'b10);
      in_drv[0] = (i + 1) < 2;
      in_drv[1] = (((i + 1) % 12) < 2) && ((i + 1) < 40);
    end
    chk("sim_busy", busy, 1'b0);
    chk("sim_overflow", overflow, 1'b0);

    // Reset mid-burst with a second event still queued.
    in_drv = 2'b01;
    for (int i = 0; i <= 100; i++) begin
      step();
      in_drv[0] = (i + 1) < 2;
      in_drv[1] = ((i + 1) == 12) || ((i + 1) == 13);
    end
    chk("rstmid_out_before", out, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_out_async", out, 2'b00);
    chk("rstmid_busy_async", busy, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 140; i++) begin
      step();
      chk($sformatf("rstmid_out@%0d", i), out, 2'b00);
      chk($sformatf("rstmid_busy@%0d", i), busy, 1'b0);
    end

    // Reset must have restored the default delay.
    run_vec(tbl[0], 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_line_mc.md
# delay_line_mc

Multi-channel, runtime-programmable delay line core. It timestamps rising edges on CHANNELS pulse inputs against a free-running counter and queues them in one shared FIFO. Each event is replayed on its channel's output as a burst exactly `delay_cycles` clocks later. It sits between the input comparators and the output drivers, and replaces the single-channel, fixed-delay top-level datapath.

## Interface
- CHANNELS, 4: number of independent input/output channel pairs.
- CTR_WIDTH, 18: timestamp counter width. The delay must be < 2^CTR_WIDTH.
- FIFO_DEPTH, 1024: number of queued events (entries), shared by all channels.
- DEFAULT_DELAY, 165000: delay in clocks after reset (1 ms at 165 MHz).
- HOLDOFF_CYCLES, 248: per-channel re-arm time after a detected edge (1.5 µs).
- HALF_PERIOD_CLKS, 5: clocks per half period of the output modulation (16.5 MHz).
- BURST_PULSES, 16: modulation periods per output burst.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in  in  CHANNELS  raw asynchronous pulse inputs.
- delay_cycles  in  CTR_WIDTH  new delay value, sampled on delay_load.
- delay_load  in  1  single-cycle request to adopt delay_cycles.
- delay_ack  out  1  single-cycle pulse, one clock after a load is accepted.
- overflow_clr  in  1  clears the sticky overflow flag.
- out  out  CHANNELS  delayed burst outputs.
- fifo_full  out  1  event FIFO is full.
- overflow  out  1  sticky flag: at least one event was dropped.
- busy  out  1  FIFO is non-empty or a burst is active.

## Operation
- **Input conditioning:** each `in` bit passes through two synchroniser flops. A 0→1 transition on the synchronised bit is an edge.
- **Holdoff:** after a detected edge, the channel ignores further edges for HOLDOFF_CYCLES clocks. A held-off edge is discarded and is not an overflow.
- **Timestamp counter:** free-running, wraps modulo 2^CTR_WIDTH, and is cleared by reset.
- **FIFO entry format:** {channel mask [CHANNELS], target = ctr + D − PIPE mod 2^CTR_WIDTH}.
  - PIPE is the fixed internal pipeline depth.
  - Edges on several channels in the same cycle produce one entry with several mask bits set.
  - Edges on different cycles always produce separate entries.
- **FIFO full:**
  - An edge arriving while fifo_full is high is dropped and sets overflow.
  - The mask bits written that cycle are lost together.
- **Overflow flag:** overflow_clr clears it. If a set event and overflow_clr occur in the same cycle, set wins.
- **Comparator:**
  - When the FIFO is non-empty and the head target equals ctr, the head is popped.
  - Every channel whose mask bit is set starts a burst.
  - Equality compare only; wrap-around is handled implicitly.
- **Burst generator, one per channel, states IDLE → ACTIVE → IDLE:**
  - ACTIVE lasts 2·HALF_PERIOD_CLKS·BURST_PULSES clocks.
  - A trigger while ACTIVE restarts the burst from its first cycle.
- **Delay register (D):**
  - Reset value is DEFAULT_DELAY.
  - delay_load is accepted only when busy = 0; it is ignored (no ack) otherwise.
  - Values below MIN_DELAY = 6 are clamped to 6.
  - A delay of 0 or one ≥ 2^CTR_WIDTH is impossible by construction.
- **Reset (asynchronous, any time):**
  - Empties the FIFO, zeroes the counter, holdoff timers and burst states, and reloads D.
  - Pending events are discarded.

## Timing
- **Reset values:** out = 0, fifo_full = 0, overflow = 0, busy = 0, delay_ack = 0.
- **Latency:** if `in` first samples high at posedge k, out first goes high at posedge k + D exactly. This holds for every D ≥ 6 and across counter wrap.
- **Holdoff window:**
  - Following an edge detected at posedge e (e = k + 3), edges detected at e+1 … e+HOLDOFF_CYCLES are ignored.
  - An edge detected at e+HOLDOFF_CYCLES+1 is accepted.
- **fifo_full / overflow timing:**
  - fifo_full asserts in the cycle after the write that fills the FIFO.
  - overflow asserts in the cycle after the dropped edge.
- **Load handshake:** delay_ack is high in the cycle after an accepted delay_load. The new D applies to edges detected from that cycle on.
- **busy:** falls the cycle after the last burst ends with the FIFO empty.

## Configuration
- DELAY_LINE_MC_MODULATION_EN defined:
  - ACTIVE output is a square wave: high for HALF_PERIOD_CLKS, then low for HALF_PERIOD_CLKS, repeated BURST_PULSES times.
  - The burst starts high.
- DELAY_LINE_MC_MODULATION_EN undefined:
  - ACTIVE output is a flat high for the full 2·HALF_PERIOD_CLKS·BURST_PULSES clocks.
  - Latency and all other behaviour are identical.

## Test plan
Bench parameters: CHANNELS=2, CTR_WIDTH=8, FIFO_DEPTH=4, HOLDOFF_CYCLES=10, HALF_PERIOD_CLKS=2, BURST_PULSES=3, DEFAULT_DELAY=20, modulation enabled.

- **Basic latency:** in[0] rises at posedge 100 → out[0] = 1100 1100 1100 over posedges 120–131, then 0. out[1] stays 0 throughout.
- **Holdoff and simultaneous edges:**
  - in[0] pulses at 100 and again at 105 → only one burst, starting at 120.
  - in[0] and in[1] rise together at 200 → both outputs burst from 220, and only one FIFO entry is used.
- **Wrap-around:** load D = 200, then fire in[0] at counter value 250 → out[0] rises exactly 200 clocks later, after the counter has wrapped.
- **Overflow:**
  - Five edges on in[0] spaced 12 clocks apart within D = 100 → fifo_full rises after the 4th edge, the 5th edge is dropped, and overflow = 1.
  - Exactly 4 bursts appear.
  - overflow_clr → overflow = 0.
- **Delay load and reset:**
  - delay_load with D = 3 while busy → ignored.
  - When idle → delay_ack pulses and D = 6 (clamped).
  - Assert rst mid-burst → out drops to 0 immediately, and no queued event appears after release.
